// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared FSM states and constants for the camera frame writer
package cam_pkg;

  // Default frame size, also used by the SDRAM DMA address map (640x480 RGB565).
  localparam int CAM_FRAME_LEN = 307200;

  // Width of the per-frame pixel counter.
  localparam int CAM_PIX_CNT_W = 21;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_SKIP    = 2'd2,
    ST_ACTIVE  = 2'd3
  } cam_state_e;

  // Saturating increment so an overlong frame cannot wrap to a "correct" count.
  function automatic logic [CAM_PIX_CNT_W-1:0] pix_cnt_inc(input logic [CAM_PIX_CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + CAM_PIX_CNT_W'(1);
  endfunction

endpackage

// File: rtl/cam_frame_writer_if.sv
// rtl/cam_frame_writer_if.sv - DVP input and write-FIFO bus between camera, writer and SDRAM side
interface cam_frame_writer_if;

  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;
  logic        wr_full;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        wr_load;
  logic        frame_done;
  logic        frame_err;
  logic        ovf;

  // The frame writer consumes the camera bus and drives the FIFO write side.
  modport master (
    input  cam_vsync, cam_href, cam_data, wr_full,
    output wr_en, wr_data, wr_load, frame_done, frame_err, ovf
  );

  // Camera/FIFO environment facing the writer.
  modport slave (
    output cam_vsync, cam_href, cam_data, wr_full,
    input  wr_en, wr_data, wr_load, frame_done, frame_err, ovf
  );

endinterface

// File: rtl/cam_byte_packer.sv
// rtl/cam_byte_packer.sv - pairs DVP bytes (high byte first) into RGB565 pixels
module cam_byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        href_i,
  input  logic [7:0]  data_i,
  output logic        pix_valid_o,
  output logic [15:0] pix_data_o
);

  logic       phase_q, phase_d;
  logic [7:0] hi_q, hi_d;

  // Phase flips per valid byte and restarts at 0 whenever href drops, so an odd trailing byte is lost.
  always_comb begin
    phase_d = href_i ? ~phase_q : 1'b0;
    hi_d    = (href_i && !phase_q) ? data_i : hi_q;
  end

  // Byte phase and latched high byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 1'b0;
      hi_q    <= 8'h00;
    end else begin
      phase_q <= phase_d;
      hi_q    <= hi_d;
    end
  end

  assign pix_valid_o = href_i & phase_q;
  assign pix_data_o  = {hi_q, data_i};

endmodule

// File: rtl/cam_frame_writer.sv
// rtl/cam_frame_writer.sv - frame-synchronised camera to SDRAM write-FIFO bridge (optional CAM_FRAME_WRITER_TESTPAT_EN)
module cam_frame_writer
  import cam_pkg::*;
#(
  parameter int FRAME_LEN   = CAM_FRAME_LEN,
  parameter int SKIP_FRAMES = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sdram_init_done,
`ifdef CAM_FRAME_WRITER_TESTPAT_EN
  input  logic               test_pat,
`endif
  cam_frame_writer_if.master cam
);

  localparam int SKIP_W = (SKIP_FRAMES > 1) ? $clog2(SKIP_FRAMES + 1) : 1;
  localparam logic [CAM_PIX_CNT_W-1:0] FRAME_LEN_C = CAM_PIX_CNT_W'(FRAME_LEN);

  cam_state_e               state_q, state_d;
  logic [SKIP_W-1:0]        skip_q, skip_d;
  logic [CAM_PIX_CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic                     init_s1_q, init_s2_q;
  logic                     vs_prev_q;
  logic                     wr_en_q, wr_en_d;
  logic [15:0]              wr_data_q, wr_data_d;
  logic                     wr_load_q, wr_load_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic                     ovf_q, ovf_d;

  logic                     init_sync;
  logic                     frame_edge;
  logic                     pix_valid;
  logic [15:0]              pix_data;
  logic [15:0]              pix_word;
  logic                     accept;

  cam_byte_packer u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .href_i      (cam.cam_href),
    .data_i      (cam.cam_data),
    .pix_valid_o (pix_valid),
    .pix_data_o  (pix_data)
  );

  assign init_sync  = init_s2_q;
  assign frame_edge = cam.cam_vsync & ~vs_prev_q;

`ifdef CAM_FRAME_WRITER_TESTPAT_EN
  assign pix_word = test_pat ? pix_cnt_q[15:0] : pix_data;
`else
  assign pix_word = pix_data;
`endif

  // init_done synchroniser and vsync history for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_s1_q <= 1'b0;
      init_s2_q <= 1'b0;
      vs_prev_q <= 1'b0;
    end else begin
      init_s1_q <= sdram_init_done;
      init_s2_q <= init_s1_q;
      vs_prev_q <= cam.cam_vsync;
    end
  end

  // Frame sequencing: wait for SDRAM, skip settling frames, then check each frame at its closing edge.
  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    wr_load_d = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    if (!init_sync) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_WAIT_VS;
        ST_WAIT_VS: begin
          if (frame_edge) begin
            skip_d = '0;
            if (SKIP_FRAMES == 0) begin
              state_d   = ST_ACTIVE;
              wr_load_d = 1'b1;
            end else begin
              state_d = ST_SKIP;
            end
          end
        end
        ST_SKIP: begin
          if (frame_edge) begin
            skip_d = skip_q + SKIP_W'(1);
            if (32'(skip_q) + 32'd1 == SKIP_FRAMES) begin
              state_d   = ST_ACTIVE;
              wr_load_d = 1'b1;
            end
          end
        end
        ST_ACTIVE: begin
          if (frame_edge) begin
            wr_load_d = 1'b1;
            if (pix_cnt_q == FRAME_LEN_C) done_d = 1'b1;
            else                          err_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Pixel path: a frame edge wins over a coincident pixel; overlong and blocked pixels are counted but not written.
  always_comb begin
    accept    = pix_valid & (state_q == ST_ACTIVE) & init_sync & ~frame_edge;
    wr_en_d   = accept & ~cam.wr_full & (pix_cnt_q < FRAME_LEN_C);
    wr_data_d = pix_valid ? pix_word : wr_data_q;
    pix_cnt_d = pix_cnt_q;
    ovf_d     = ovf_q;
    if (frame_edge) begin
      pix_cnt_d = '0;
      ovf_d     = 1'b0;
    end else if (accept) begin
      pix_cnt_d = pix_cnt_inc(pix_cnt_q);
      if (cam.wr_full) ovf_d = 1'b1;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      skip_q    <= '0;
      pix_cnt_q <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= 16'h0000;
      wr_load_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      skip_q    <= skip_d;
      pix_cnt_q <= pix_cnt_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      wr_load_q <= wr_load_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ovf_q     <= ovf_d;
    end
  end

  assign cam.wr_en      = wr_en_q;
  assign cam.wr_data    = wr_data_q;
  assign cam.wr_load    = wr_load_q;
  assign cam.frame_done = done_q;
  assign cam.frame_err  = err_q;
  assign cam.ovf        = ovf_q;

endmodule

// File: tb/tb_cam_frame_writer.sv
// tb/tb_cam_frame_writer.sv - randomized frame stimulus checked against a frame-level reference model
module tb_cam_frame_writer;
  import cam_pkg::*;

  localparam int FL   = 8;
  localparam int SKIP = 2;

  logic clk;
  logic rst_n;
  logic init;

  cam_frame_writer_if bus();

  cam_frame_writer #(.FRAME_LEN(FL), .SKIP_FRAMES(SKIP)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sdram_init_done (init),
    .cam             (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: expected outputs after each clock edge.
  bit          exp_en, exp_load, exp_done, exp_err, exp_ovf;
  logic [15:0] exp_data;
  bit          m_q1, m_q2, m_vs_prev, m_ready;
  int          m_edges, m_cnt, m_run;
  logic [7:0]  m_hi;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_en = 0; exp_load = 0; exp_done = 0; exp_err = 0; exp_ovf = 0; exp_data = 16'h0;
        m_q1 = 0; m_q2 = 0; m_vs_prev = 0; m_ready = 0; m_edges = 0; m_cnt = 0; m_run = 0; m_hi = 8'h0;
      end else begin
        bit sync_now, edge_now, pix_now;
        sync_now = m_q2;
        edge_now = bus.cam_vsync && !m_vs_prev;
        pix_now  = bus.cam_href && (m_run % 2 == 1);
        exp_en = 0; exp_load = 0; exp_done = 0; exp_err = 0;
        if (!sync_now) begin
          m_ready = 0;
          m_edges = 0;
        end else if (!m_ready) begin
          m_ready = 1;
        end else if (edge_now) begin
          if (m_edges >= SKIP + 1) begin
            if (m_cnt == FL) exp_done = 1;
            else             exp_err  = 1;
          end
          if (m_edges < SKIP + 1) m_edges++;
          if (m_edges >= SKIP + 1) exp_load = 1;
        end else if (pix_now && m_edges >= SKIP + 1) begin
          exp_en   = !bus.wr_full && (m_cnt < FL);
          exp_data = {m_hi, bus.cam_data};
          if (bus.wr_full) exp_ovf = 1;
          if (m_cnt < (1 << 21) - 1) m_cnt++;
        end
        if (edge_now) begin
          m_cnt   = 0;
          exp_ovf = 0;
        end
        if (bus.cam_href && (m_run % 2 == 0)) m_hi = bus.cam_data;
        m_run     = bus.cam_href ? m_run + 1 : 0;
        m_vs_prev = bus.cam_vsync;
        m_q2      = m_q1;
        m_q1      = init;
      end
    end
  end

  // Event tallies used by the directed scenario checks.
  int          tot_en = 0, tot_load = 0, tot_done = 0, tot_err = 0;
  bit          seen_wd = 0;
  logic [15:0] first_wd = 16'h0;

  // Cycle-by-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check("wr_en", bus.wr_en, exp_en);
      check("wr_load", bus.wr_load, exp_load);
      check("frame_done", bus.frame_done, exp_done);
      check("frame_err", bus.frame_err, exp_err);
      check("ovf", bus.ovf, exp_ovf);
      if (exp_en) check("wr_data", bus.wr_data, exp_data);
      if (bus.wr_en) begin
        tot_en++;
        if (!seen_wd) begin
          first_wd = bus.wr_data;
          seen_wd  = 1;
        end
      end
      if (bus.wr_load)    tot_load++;
      if (bus.frame_done) tot_done++;
      if (bus.frame_err)  tot_err++;
    end
  end

  int          full_pix  = -1;
  int          full_rate = 0;
  bit          use_first = 0;
  logic [15:0] first_px  = 16'h0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic edge_pulse();
    bus.cam_vsync = 1'b1;
    tick(); tick();
    bus.cam_vsync = 1'b0;
    repeat (3) tick();
  endtask

  task automatic send_line(input int nbytes, inout int pix);
    for (int b = 0; b < nbytes; b++) begin
      bus.cam_href = 1'b1;
      if (use_first && pix == 0) bus.cam_data = (b % 2 == 0) ? first_px[15:8] : first_px[7:0];
      else                       bus.cam_data = 8'($urandom);
      bus.wr_full = (b % 2 == 1) &&
                    ((pix == full_pix) || (full_rate != 0 && $urandom_range(full_rate - 1) == 0));
      tick();
      if (b % 2 == 1) pix++;
    end
    bus.cam_href = 1'b0;
    bus.wr_full  = 1'b0;
    bus.cam_data = 8'($urandom);
    repeat (2 + $urandom_range(2)) tick();
  endtask

  task automatic send_frame(input int npix, input int width);
    int pix;
    int w;
    pix = 0;
    while (pix < npix) begin
      w = (npix - pix < width) ? npix - pix : width;
      send_line(2 * w, pix);
    end
    edge_pulse();
  endtask

  initial begin
    int s_en, s_done, s_err, pix;
    rst_n = 1'b0; init = 1'b0;
    bus.cam_vsync = 1'b0; bus.cam_href = 1'b0; bus.cam_data = 8'h00; bus.wr_full = 1'b0;
    repeat (3) tick();
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_wr_data", bus.wr_data, 16'h0000);
    check("rst_wr_load", bus.wr_load, 0);
    check("rst_frame_done", bus.frame_done, 0);
    check("rst_frame_err", bus.frame_err, 0);
    check("rst_ovf", bus.ovf, 0);
    check("rst_state", dut.state_q, ST_IDLE);
    rst_n = 1'b1;
    tick();
    init = 1'b1;
    repeat (5) tick();

    // Settling frames, then two good 4x2 frames; first active pixel is F8/1F.
    edge_pulse();
    send_frame(8, 4);
    send_frame(8, 4);
    check("skip_no_wr_en", tot_en, 0);
    check("load_at_edge3", tot_load, 1);
    seen_wd = 0; use_first = 1; first_px = 16'hF81F;
    send_frame(8, 4);
    use_first = 0;
    check("frame3_wr_en", tot_en, 8);
    check("done_edge4", tot_done, 1);
    check("first_pixel", first_wd, 16'hF81F);
    send_frame(8, 4);
    check("frame4_wr_en", tot_en, 16);
    check("done_edge5", tot_done, 2);
    check("load_count", tot_load, 3);

    // Odd-length line: trailing byte dropped, next line starts at phase 0.
    s_en = tot_en; s_done = tot_done;
    pix = 0;
    send_line(5, pix);
    send_line(12, pix);
    edge_pulse();
    check("odd_line_wr_en", tot_en - s_en, 8);
    check("odd_line_done", tot_done - s_done, 1);

    // FIFO full on pixel 3.
    s_en = tot_en; s_done = tot_done;
    full_pix = 2; pix = 0;
    send_line(8, pix);
    send_line(8, pix);
    full_pix = -1;
    check("ovf_sticky", bus.ovf, 1);
    edge_pulse();
    check("ovf_cleared", bus.ovf, 0);
    check("full_wr_en", tot_en - s_en, 7);
    check("full_done", tot_done - s_done, 1);

    // Short and long frames.
    s_en = tot_en; s_done = tot_done; s_err = tot_err;
    send_frame(6, 4);
    check("short_err", tot_err - s_err, 1);
    check("short_no_done", tot_done - s_done, 0);
    s_en = tot_en; s_err = tot_err;
    send_frame(10, 4);
    check("long_wr_en", tot_en - s_en, 8);
    check("long_err", tot_err - s_err, 1);

    // SDRAM not ready mid-line.
    bus.cam_href = 1'b1;
    for (int b = 0; b < 12; b++) begin
      bus.cam_data = 8'($urandom);
      if (b == 2) init = 1'b0;
      if (b == 5) s_en = tot_en;
      tick();
    end
    bus.cam_href = 1'b0;
    repeat (3) tick();
    check("drop_no_wr_en", tot_en - s_en, 0);
    check("drop_state", dut.state_q, ST_IDLE);
    init = 1'b1;
    repeat (5) tick();
    s_en = tot_en;
    edge_pulse();
    send_frame(8, 4);
    send_frame(8, 4);
    check("reinit_skip", tot_en - s_en, 0);
    send_frame(8, 4);
    check("reinit_resume", tot_en - s_en, 8);

    // Reset in the middle of a line.
    pix = 0;
    send_line(6, pix);
    bus.cam_href = 1'b1;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    bus.cam_href = 1'b0;
    repeat (3) tick();
    s_en = tot_en;
    edge_pulse();
    send_frame(8, 3);
    send_frame(8, 2);
    check("post_reset_skip", tot_en - s_en, 0);

    // Random frames with random widths, stray bytes and FIFO back-pressure.
    full_rate = 6;
    for (int f = 0; f < 30; f++) begin
      int n;
      n = ($urandom_range(2) == 0) ? 8 : 5 + $urandom_range(6);
      pix = 0;
      if ($urandom_range(3) == 0) send_line(1, pix);
      pix = 0;
      send_frame(n, 1 + $urandom_range(4));
    end
    full_rate = 0;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
